cnt8_timer_ctl: RTL and testbench

Programmable interval timer controller built around an 8-bit loadable up-counter with carry-out. It sequences the counter's load, enable and clear controls to produce one-shot or periodic ticks from an 8-bit period value. It sits between a host or register block and the counter datapath, and the team uses it as the standard timing source for macro-level designs.

---
 rtl/cnt8_tmr_pkg.sv | 18 +
 rtl/cnt8_timer_ctl_if.sv | 33 +++
 rtl/cnt8_core.sv | 26 ++
 rtl/cnt8_timer_ctl.sv | 111 +++++++++++
 tb/tb_cnt8_timer_ctl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cnt8_tmr_pkg.sv
// Shared types and constants for the cnt8 interval timer.
// Optional prescaler feature is enabled by defining CNT8_TMR_PRESCALE_EN.
package cnt8_tmr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] CNT8_TERM = 8'hFF;
  localparam int         PSC_W     = 4;

  // The counter counts up from this value and terminates at CNT8_TERM.
  function automatic logic [7:0] load_value(input logic [7:0] period);
    return CNT8_TERM - period;
  endfunction

endpackage

// File: rtl/cnt8_timer_ctl_if.sv
// Host-side bundle of the interval timer; psc exists only with CNT8_TMR_PRESCALE_EN.
interface cnt8_timer_ctl_if;
  import cnt8_tmr_pkg::*;

  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] period;
`ifdef CNT8_TMR_PRESCALE_EN
  logic [PSC_W-1:0] psc;
`endif
  logic [7:0] cnt;
  logic       tick;
  logic       done;
  logic       busy;

  modport master (
`ifdef CNT8_TMR_PRESCALE_EN
    output psc,
`endif
    output start, stop, mode, period,
    input  cnt, tick, done, busy
  );

  modport slave (
`ifdef CNT8_TMR_PRESCALE_EN
    input  psc,
`endif
    input  start, stop, mode, period,
    output cnt, tick, done, busy
  );

endinterface

// File: rtl/cnt8_core.sv
// 8-bit loadable up-counter with carry-out.
// Priority: async clear cd, sync clear cs, load ld, increment (cai && en).
module cnt8_core
  import cnt8_tmr_pkg::*;
(
  input  logic       clk,
  input  logic       cd,
  input  logic       cs,
  input  logic       ld,
  input  logic [7:0] d,
  input  logic       cai,
  input  logic       en,
  output logic [7:0] q,
  output logic       cao
);

  always_ff @(posedge clk or posedge cd) begin
    if (cd)             q <= 8'h00;
    else if (cs)        q <= 8'h00;
    else if (ld)        q <= d;
    else if (cai && en) q <= q + 8'h01;
  end

  assign cao = cai && en && (q == CNT8_TERM);

endmodule

// File: rtl/cnt8_timer_ctl.sv
// Interval timer controller sequencing cnt8_core for one-shot/periodic ticks.
// Define CNT8_TMR_PRESCALE_EN to add the 4-bit clock-enable prescaler.
module cnt8_timer_ctl
  import cnt8_tmr_pkg::*;
(
  input  logic            clk,
  input  logic            cd,
  cnt8_timer_ctl_if.slave bus
);

  state_t     state, state_next;
  logic       mode_q;
  logic [7:0] period_q;
  logic       done_q;
  logic       cs, ld, capture, done_next;
  logic       ce, cao, run;
  logic [7:0] load_val;

  assign run = (state == RUN);

`ifdef CNT8_TMR_PRESCALE_EN
  logic [PSC_W-1:0] psc_q, psc_cnt;

  // Divider restarts on every load/reload so the first ce lands psc+1 cycles later.
  always_ff @(posedge clk or posedge cd) begin
    if (cd) begin
      psc_q   <= '0;
      psc_cnt <= '0;
    end else begin
      if (capture) psc_q <= bus.psc;
      if (ld || cs || ce) psc_cnt <= '0;
      else                psc_cnt <= psc_cnt + 1'b1;
    end
  end

  assign ce = (psc_cnt == psc_q);
`else
  assign ce = 1'b1;
`endif

  always_ff @(posedge clk or posedge cd) begin
    if (cd) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      period_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      if (capture) begin
        mode_q   <= bus.mode;
        period_q <= bus.period;
      end
    end
  end

  always_comb begin
    state_next = state;
    cs         = 1'b0;
    ld         = 1'b0;
    capture    = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          ld         = 1'b1;
          capture    = 1'b1;
          state_next = RUN;
        end else begin
          cs = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          cs         = 1'b1;
          state_next = IDLE;
        end else if (bus.start) begin
          ld      = 1'b1;
          capture = 1'b1;
        end else if (cao && !mode_q) begin
          cs         = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cao) begin
          ld = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fresh starts take the live period; periodic reloads reuse the captured one.
  assign load_val = capture ? load_value(bus.period) : load_value(period_q);

  cnt8_core u_core (
    .clk (clk),
    .cd  (cd),
    .cs  (cs),
    .ld  (ld),
    .d   (load_val),
    .cai (run),
    .en  (ce),
    .q   (bus.cnt),
    .cao (cao)
  );

  assign bus.tick = cao;
  assign bus.busy = run;
  assign bus.done = done_q;

endmodule

// File: tb/tb_cnt8_timer_ctl.sv
// Self-checking bench for cnt8_timer_ctl against an elapsed-cycle timer model.
// Honours CNT8_TMR_PRESCALE_EN by driving psc and scaling the model interval.
module tb_cnt8_timer_ctl;

  logic clk = 1'b0;
  logic cd  = 1'b1;

  cnt8_timer_ctl_if bus ();

  cnt8_timer_ctl dut (
    .clk (clk),
    .cd  (cd),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: cycles elapsed since the last load; count and tick derive from it.
  bit m_run  = 1'b0;
  bit m_mode = 1'b0;
  bit m_done = 1'b0;
  int m_per  = 0;
  int m_k    = 1;
  int m_elapsed = 0;

  function automatic bit model_tick();
    return m_run && (m_elapsed == (m_per + 1) * m_k - 1);
  endfunction

  task automatic check_output(input string tag);
    logic [7:0] exp_cnt;
    logic       exp_tick;
    exp_cnt  = m_run ? 8'(255 - m_per + m_elapsed / m_k) : 8'h00;
    exp_tick = model_tick();
    checks++;
    assert (bus.cnt === exp_cnt) else begin
      errors++;
      $error("[TB] FAIL %s cnt: got %h expected %h", tag, bus.cnt, exp_cnt);
    end
    checks++;
    assert (bus.tick === exp_tick) else begin
      errors++;
      $error("[TB] FAIL %s tick: got %b expected %b", tag, bus.tick, exp_tick);
    end
    checks++;
    assert (bus.done === m_done) else begin
      errors++;
      $error("[TB] FAIL %s done: got %b expected %b", tag, bus.done, m_done);
    end
    checks++;
    assert (bus.busy === m_run) else begin
      errors++;
      $error("[TB] FAIL %s busy: got %b expected %b", tag, bus.busy, m_run);
    end
  endtask

  task automatic model_load(input bit md, input logic [7:0] per, input int psc);
    m_run     = 1'b1;
    m_mode    = md;
    m_per     = int'(per);
    m_k       = psc + 1;
    m_elapsed = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit md,
                            input logic [7:0] per, input int psc);
    bit t;
    t      = model_tick();
    m_done = 1'b0;
    if (!m_run) begin
      if (s && !p) model_load(md, per, psc);
    end else if (p) begin
      m_run = 1'b0;
    end else if (s) begin
      model_load(md, per, psc);
    end else if (t) begin
      if (!m_mode) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else begin
        m_elapsed = 0;
      end
    end else begin
      m_elapsed++;
    end
  endtask

  // One clock cycle: drive at negedge, check, advance model, wait for posedge.
  task automatic apply_stimulus(input bit s, input bit p, input bit md,
                                input logic [7:0] per, input int psc,
                                input string tag);
    @(negedge clk);
    bus.start  = s;
    bus.stop   = p;
    bus.mode   = md;
    bus.period = per;
`ifdef CNT8_TMR_PRESCALE_EN
    bus.psc    = 4'(psc);
`endif
    #1;
    check_output(tag);
    model_step(s, p, md, per, psc);
    @(posedge clk);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 0, tag);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    cd        = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    m_run     = 1'b0;
    m_done    = 1'b0;
    m_elapsed = 0;
    #1;
    check_output(tag);
    @(posedge clk);
    #1;
    cd = 1'b0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.mode   = 1'b0;
    bus.period = 8'h00;
`ifdef CNT8_TMR_PRESCALE_EN
    bus.psc    = '0;
`endif
    reset_pulse("reset");

    apply_stimulus(1'b1, 1'b0, 1'b0, 8'd5, 0, "oneshot_start");
    idle_cycles(10, "oneshot");

    apply_stimulus(1'b1, 1'b0, 1'b1, 8'd3, 0, "periodic_start");
    idle_cycles(40, "periodic");
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 0, "periodic_stop");

    apply_stimulus(1'b1, 1'b0, 1'b1, 8'd0, 0, "p0_start");
    idle_cycles(10, "p0_periodic");
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 0, "p0_stop");

    apply_stimulus(1'b1, 1'b0, 1'b0, 8'd255, 0, "p255_start");
    idle_cycles(260, "p255");

    apply_stimulus(1'b1, 1'b0, 1'b1, 8'd2, 0, "stoptick_start");
    idle_cycles(2, "stoptick_run");
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 0, "stoptick_stop");
    idle_cycles(3, "stoptick_after");

    apply_stimulus(1'b1, 1'b0, 1'b0, 8'd2, 0, "restart_start");
    idle_cycles(2, "restart_run");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'd4, 0, "restart_tick");
    idle_cycles(8, "restart_after");

    apply_stimulus(1'b1, 1'b1, 1'b1, 8'd1, 0, "idle_start_stop");
    idle_cycles(2, "idle_hold");

    apply_stimulus(1'b1, 1'b0, 1'b1, 8'hBF, 0, "cd_load40");
    idle_cycles(1, "cd_at40");
    reset_pulse("cd_midrun");
    idle_cycles(2, "cd_after");

`ifdef CNT8_TMR_PRESCALE_EN
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'd3, 2, "psc_start");
    idle_cycles(40, "psc_periodic");
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 0, "psc_stop");
`endif

    // Random traffic: mostly short periods so ticks, restarts and stops collide often.
    for (int i = 0; i < 3000; i++) begin
      bit         s, p, md;
      logic [7:0] per;
      int         psc;
      s   = ($urandom_range(0, 15) == 0);
      p   = ($urandom_range(0, 31) == 0);
      md  = 1'($urandom_range(0, 1));
      per = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
`ifdef CNT8_TMR_PRESCALE_EN
      psc = $urandom_range(0, 3);
`else
      psc = 0;
`endif
      apply_stimulus(s, p, md, per, psc, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
